// File: rtl/jtopl_wrq_pkg.sv
// Shared definitions for the OPL host write queue: replay FSM encoding,
// default post-write wait times and queue entry sizing helpers.
package jtopl_wrq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wrq_state_e;

  localparam int unsigned DEF_ADDR_WAIT = 12;
  localparam int unsigned DEF_DATA_WAIT = 84;

  // One queue entry holds {addr, din}
  function automatic int unsigned entry_w(input int unsigned aw);
    return aw + 8;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtopl_wrq_fifo.sv
// Synchronous FIFO for queued host writes. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and
// drop_o flags it for that cycle.
module jtopl_wrq_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); count has one extra bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jtopl_wrq.sv
// Host-bus front end for the OPL core: queues CPU register writes and replays
// them into the core, holding off after each write for the chip's wait time.
// Optional feature macro JTOPL_WRQ_BUSY_EN: when defined, dout[0] reports
// busy (queue non-empty or replay in progress); otherwise dout = status.
//
// state | meaning
// IDLE  | waiting for a queued entry; loads core_din/core_addr and pops it
// ISSUE | core_wr pulses for one cen cycle; wait counter loaded
// WAIT  | counting down the post-write hold-off
module jtopl_wrq
  import jtopl_wrq_pkg::*;
#(
  parameter int AW        = 1,
  parameter int DEPTH     = 16,
  parameter int ADDR_WAIT = DEF_ADDR_WAIT,
  parameter int DATA_WAIT = DEF_DATA_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [7:0]    din,
  input  logic [AW-1:0] addr,
  input  logic          cs_n,
  input  logic          wr_n,
  input  logic [7:0]    status,
  output logic [7:0]    dout,
  output logic [7:0]    core_din,
  output logic [AW-1:0] core_addr,
  output logic          core_wr,
  output logic          ovf
);

  localparam int EW     = entry_w(AW);
  localparam int CW_RAW = $clog2(max_u(ADDR_WAIT, DATA_WAIT));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_WAIT - 1);

  wrq_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [7:0]            core_din_q;
  logic [AW-1:0]         core_addr_q;
  logic                  wr_q;
  logic                  ovf_q;

  logic                  wr_act;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [EW-1:0]         fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_drop;
  logic [$clog2(DEPTH):0] fifo_count;

  assign wr_act    = !cs_n && !wr_n;
  assign fifo_push = wr_act && !wr_q;
  assign fifo_pop  = cen && (state_q == IDLE) && !fifo_empty;

  jtopl_wrq_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({addr, din}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  // Occupancy is exported for observation; replay only needs empty/full
  logic unused_fifo;
  assign unused_fifo = ^{fifo_count, fifo_full};

  // Strobe edge detector and sticky overflow flag (both run every clk)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_act;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  // Replay FSM with wait counter; advances only on cen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      core_din_q  <= '0;
      core_addr_q <= '0;
    end else if (cen) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            core_addr_q <= fifo_head[EW-1:8];
            core_din_q  <= fifo_head[7:0];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= core_addr_q[0] ? DATA_LOAD : ADDR_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so a pending ISSUE cannot strobe the core during reset
  assign core_wr   = rst_n && cen && (state_q == ISSUE);
  assign core_din  = core_din_q;
  assign core_addr = core_addr_q;
  assign ovf       = ovf_q;

`ifdef JTOPL_WRQ_BUSY_EN
  logic busy;
  logic unused_status;
  assign busy          = !fifo_empty || (state_q != IDLE);
  assign unused_status = status[0];
  assign dout          = {status[7:1], busy};
`else
  assign dout = status;
`endif

endmodule

// File: tb/tb_jtopl_wrq.sv
module tb_jtopl_wrq;

  localparam int AW = 1;

  logic          clk;
  logic          rst_n;
  logic          cen;
  logic [7:0]    din;
  logic [AW-1:0] addr;
  logic          cs_n;
  logic          wr_n;
  logic [7:0]    status;
  logic [7:0]    dout;
  logic [7:0]    core_din;
  logic [AW-1:0] core_addr;
  logic          core_wr;
  logic          ovf;

  jtopl_wrq #(.AW(AW), .DEPTH(16), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .din       (din),
    .addr      (addr),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .status    (status),
    .dout      (dout),
    .core_din  (core_din),
    .core_addr (core_addr),
    .core_wr   (core_wr),
    .ovf       (ovf)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            sp_tick;
    int            sp_clk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cen_mode = 1;
  int   phase    = 0;
  int   tick_cnt = 0;
  int   clk_cnt  = 0;
  int   last_tick = 0;
  int   last_clk  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected host read value for a given busy state
  function automatic logic [7:0] exp_dout(input logic busy);
`ifdef JTOPL_WRQ_BUSY_EN
    return {status[7:1], busy};
`else
    return status;
`endif
  endfunction

  // Monitor: every core_wr pulse pops the scoreboard and is compared
  initial begin
    forever begin
      @(negedge clk);
      clk_cnt++;
      if (cen) tick_cnt++;
      if (core_wr) begin
        if (!rst_n) chk("core_wr_in_reset", 1, 0);
        if (sb.size() == 0) begin
          chk("unexpected_core_wr", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("core_addr", int'(core_addr), int'(e.a));
          chk("core_din", int'(core_din), int'(e.d));
          if (e.sp_tick >= 0) chk("spacing_cen_ticks", tick_cnt - last_tick, e.sp_tick);
          if (e.sp_clk >= 0)  chk("spacing_clk", clk_cnt - last_clk, e.sp_clk);
        end
        last_tick = tick_cnt;
        last_clk  = clk_cnt;
      end
    end
  end

  // One clock step; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (cen_mode == 0) begin
      cen = 1'b0;
    end else begin
      cen   = (phase == 0);
      phase = (phase + 1) % cen_mode;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d,
                          input bit stored, input int sp_t, input int sp_c);
    exp_t e;
    addr = a;
    din  = d;
    cs_n = 1'b0;
    wr_n = 1'b0;
    if (stored) begin
      e.a = a; e.d = d; e.sp_tick = sp_t; e.sp_clk = sp_c;
      sb.push_back(e);
    end
    tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name, input int budget, input int settle);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    if (sb.size() != 0) begin
      chk({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (settle) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int sp;
    rst_n  = 1'b0;
    cen    = 1'b1;
    din    = 8'h00;
    addr   = '0;
    cs_n   = 1'b1;
    wr_n   = 1'b1;
    status = 8'hC6;

    // Reset
    do_reset();
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_core_din", int'(core_din), 0);
    chk("reset_core_addr", int'(core_addr), 0);
    chk("reset_fifo_count", int'(dut.u_fifo.count_o), 0);
    chk("reset_dout", int'(dout), int'(exp_dout(1'b0)));

    // Back-to-back address then data port writes, 3 clk apart
    cen_mode = 1; phase = 0;
    do_write(1'b0, 8'h20, 1'b1, -1, -1);
    tick();
    do_write(1'b1, 8'h01, 1'b1, 14, 14);
    drain("b2b", 200, 100);

    // Data-port wait with cen 1-in-4
    cen_mode = 4; phase = 0;
    tick();
    do_write(1'b1, 8'h11, 1'b1, -1, -1);
    do_write(1'b1, 8'h22, 1'b1, 86, 344);
    drain("data_wait", 1200, 400);

    // Overflow: FSM stalled (cen low), 17 rising strobes
    cen_mode = 0;
    tick();
    for (int i = 0; i < 17; i++) begin
      if (i == 0)           sp = -1;
      else if ((i - 1) % 2) sp = 86;
      else                  sp = 14;
      do_write(AW'(i % 2), 8'h40 + 8'(i), (i < 16), sp, sp);
      if (i == 15) chk("ovf_before_17th", int'(ovf), 0);
    end
    chk("ovf_after_17th", int'(ovf), 1);
    chk("fifo_count_full", int'(dut.u_fifo.count_o), 16);
    status = 8'h26;
    chk("dout_while_queued", int'(dout), int'(exp_dout(1'b1)));
    cen_mode = 1; phase = 0;
    drain("overflow", 2000, 100);
    chk("ovf_sticky", int'(ovf), 1);

    // Full + same-cycle pop: strobe lands on the cycle IDLE pops
    do_reset();
    chk("ovf_cleared_by_reset", int'(ovf), 0);
    cen_mode = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 0)           sp = -1;
      else if ((i - 1) % 2) sp = 86;
      else                  sp = 14;
      do_write(AW'(i % 2), 8'h80 + 8'(i), 1'b1, sp, sp);
    end
    chk("fullpop_count_before", int'(dut.u_fifo.count_o), 16);
    cen_mode = 1; phase = 0;
    cen = 1'b1;
    do_write(1'b1, 8'hAA, 1'b1, 86, 86);
    chk("fullpop_ovf", int'(ovf), 0);
    chk("fullpop_count_after", int'(dut.u_fifo.count_o), 16);
    drain("fullpop", 2000, 100);
    chk("fullpop_ovf_end", int'(ovf), 0);

    // Held strobe: 10 clk low enqueues once; busy/dout behaviour
    status = 8'hA6;
    begin
      exp_t e;
      e.a = 1'b0; e.d = 8'h55; e.sp_tick = -1; e.sp_clk = -1;
      sb.push_back(e);
    end
    addr = 1'b0;
    din  = 8'h55;
    cs_n = 1'b0;
    wr_n = 1'b0;
    tick();
    tick();
    chk("held_dout_busy_early", int'(dout), int'(exp_dout(1'b1)));
    repeat (8) tick();
    chk("held_dout_busy_wait", int'(dout), int'(exp_dout(1'b1)));
    cs_n = 1'b1;
    wr_n = 1'b1;
    repeat (20) tick();
    chk("held_dout_idle", int'(dout), int'(exp_dout(1'b0)));
    chk("held_fifo_empty", int'(dut.u_fifo.count_o), 0);
    drain("held", 100, 20);
    chk("held_single_entry", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
